// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Command front-end for the 32-bit combinational ALU. Commands {op, a, b}
//   are queued in a small FIFO and issued one at a time on registered ALU
//   operand/opcode outputs. The ALU result is captured one cycle later and
//   held on a valid/ready result port, tagged with its opcode.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_op, cmd_a, cmd_b           command payload
//   alu_a, alu_b, alu_inp          registered operands/opcode to the ALU
//   alu_out                        combinational ALU result
//   res_valid/res_ready            result handshake
//   res_data, res_op               captured result and its opcode
//   busy                           FIFO non-empty or a command in flight
module alu_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_inp,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [2:0]       res_op,
    output logic             busy
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    state_t           state_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] a_mem  [DEPTH];
    logic [WIDTH-1:0] b_mem  [DEPTH];
    logic [2:0]       op_mem [DEPTH];

    logic [WIDTH-1:0] alu_a_q, alu_b_q, res_data_q;
    logic [2:0]       alu_inp_q, res_op_q;
    logic             res_valid_q;

    logic push, pop, fifo_empty;

    assign fifo_empty = (count_q == '0);
    // Ready comes from the registered count only, so a pop in the same
    // cycle never opens a slot for a push into a full FIFO.
    assign cmd_ready  = (count_q != FULL);
    assign push       = cmd_valid && cmd_ready;
    // Issue from IDLE, or straight out of HOLD when the result is taken.
    assign pop        = !fifo_empty &&
                        ((state_q == IDLE) || ((state_q == HOLD) && res_ready));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage: no reset needed, entries are only read after a push.
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_q]  <= cmd_a;
            b_mem[wr_ptr_q]  <= cmd_b;
            op_mem[wr_ptr_q] <= cmd_op;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_inp_q   <= '0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            if (pop) begin
                alu_a_q   <= a_mem[rd_ptr_q];
                alu_b_q   <= b_mem[rd_ptr_q];
                alu_inp_q <= op_mem[rd_ptr_q];
            end
            case (state_q)
                IDLE: begin
                    if (pop) state_q <= EXEC;
                end
                EXEC: begin
                    // ALU has had a full cycle to settle on the issued operands.
                    res_data_q  <= alu_out;
                    res_op_q    <= alu_inp_q;
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= pop ? EXEC : IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_inp   = alu_inp_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;
    assign res_valid = res_valid_q;
    assign busy      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int W     = 32;
    localparam int NRAND = 60;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_a, cmd_b;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic [2:0]    alu_inp;
    logic          res_valid, res_ready;
    logic [W-1:0]  res_data;
    logic [2:0]    res_op;
    logic          busy;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] d;
    } exp_t;

    exp_t         model_q[$];
    logic [W-1:0] got_q[$];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: stands in for the real ALU and serves as the reference.
    function automatic logic [W-1:0] ref_alu(input logic [2:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            3'd0:    return '0;
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a << 1;
            3'd4:    return a >> 1;
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out = ref_alu(alu_inp, alu_a, alu_b);

    alu_op_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_inp(alu_inp), .alu_out(alu_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .busy(busy)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command and hold it until it is accepted at an edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        exp_t e;
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk("send_ready", W'(cmd_ready), 1);
        if (cmd_ready) begin
            e.op = op; e.d = ref_alu(op, a, b);
            model_q.push_back(e);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Compare the presented result with the oldest outstanding command.
    task automatic take(input string tag);
        exp_t e;
        chk({tag, "_nonempty"}, W'(model_q.size() != 0), 1);
        if (model_q.size() != 0) begin
            e = model_q.pop_front();
            chk({tag, "_data"}, res_data, e.d);
            chk({tag, "_op"}, W'(res_op), W'(e.op));
        end
    endtask

    task automatic drain(input int n, output int cyc);
        int got = 0;
        cyc = 0;
        got_q.delete();
        res_ready = 1'b1;
        while (got < n && cyc < 200) begin
            if (res_valid) begin
                take("drain");
                got_q.push_back(res_data);
                got++;
            end
            tick();
            cyc++;
        end
        res_ready = 1'b0;
        chk("drain_count", W'(got), W'(n));
    endtask

    initial begin
        int cyc;
        int sent, got;
        bit acc;
        logic [W-1:0] r1;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
        #1;
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_inp", W'(alu_inp), 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_op", W'(res_op), 0);
        chk("rst_res_valid", W'(res_valid), 0);
        chk("rst_busy", W'(busy), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", W'(cmd_ready), 1);

        // Single add, latency and busy release.
        send(3'b001, 32'h5, 32'h3);
        chk("add_e0_valid", W'(res_valid), 0);
        chk("add_e0_busy", W'(busy), 1);
        tick();
        chk("add_e1_valid", W'(res_valid), 0);
        chk("add_e1_alu_a", alu_a, 32'h5);
        chk("add_e1_alu_inp", W'(alu_inp), 1);
        tick();
        chk("add_e2_valid", W'(res_valid), 1);
        chk("add_data", res_data, 32'h8);
        chk("add_op", W'(res_op), 1);
        take("add");
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("add_done_valid", W'(res_valid), 0);
        chk("add_done_busy", W'(busy), 0);

        // Sub wrap-around and clear.
        send(3'b010, 32'h1, 32'h2);
        send(3'b000, 32'hDEAD_BEEF, 32'h1234_5678);
        drain(2, cyc);
        chk("sub_wrap", got_q[0], 32'hFFFF_FFFF);
        chk("clr", got_q[1], 32'h0);
        chk("sub_clr_busy", W'(busy), 0);

        // Fill: 4 queued plus 1 in flight, result held without res_ready.
        send(3'b111, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        send(3'b110, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        send(3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        send(3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("fill4_ready", W'(cmd_ready), 1);
        send(3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk("full_ready", W'(cmd_ready), 0);
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", W'(res_valid), 1);
            chk("hold_data", res_data, 32'hFF00_FF00);
            tick();
        end
        // Push attempt while full coincides with a pop: must be refused.
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_a = 32'h1; cmd_b = 32'h1;
        res_ready = 1'b1;
        chk("full_r1", res_data, 32'hFF00_FF00);
        take("full_r1");
        tick();
        cmd_valid = 1'b0;
        chk("full_no_push_ready", W'(cmd_ready), 1);
        drain(4, cyc);
        chk("full_r2", got_q[0], 32'hFFF0_FFF0);
        chk("full_r3", got_q[1], 32'h00F0_00F0);
        chk("full_r4", got_q[2], 32'hE1E1_E1E0);
        chk("full_r5", got_q[3], 32'h7878_7878);
        chk("throughput_cycles", W'(cyc), 8);
        chk("full_done_busy", W'(busy), 0);

        // Simultaneous push and pop with two queued.
        send(3'b001, 32'h10, 32'h20);
        send(3'b010, 32'h100, 32'h1);
        send(3'b101, 32'hFFFF_0000, 32'h0F0F_0F0F);
        cmd_valid = 1'b1; cmd_op = 3'b110; cmd_a = 32'h0000_00A0; cmd_b = 32'h0000_000B;
        model_q.push_back('{op: 3'b110, d: 32'h0000_00AB});
        res_ready = 1'b1;
        take("pp_r1");
        tick();
        cmd_valid = 1'b0; res_ready = 1'b0;
        send(3'b011, 32'h8000_0001, 32'h0);
        chk("pp_count3_ready", W'(cmd_ready), 1);
        send(3'b100, 32'h8000_0001, 32'h0);
        chk("pp_count4_ready", W'(cmd_ready), 0);
        drain(5, cyc);
        chk("pp_done_busy", W'(busy), 0);

        // Asynchronous reset while in EXEC with three queued.
        send(3'b001, 32'h1, 32'h1);
        send(3'b001, 32'h2, 32'h2);
        send(3'b001, 32'h3, 32'h3);
        send(3'b001, 32'h4, 32'h4);
        cmd_valid = 1'b1; cmd_op = 3'b111; cmd_a = 32'h5; cmd_b = 32'h6;
        res_ready = 1'b1;
        tick();
        cmd_valid = 1'b0; res_ready = 1'b0;
        chk("pre_rst_exec_valid", W'(res_valid), 0);
        chk("pre_rst_busy", W'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_inp", W'(alu_inp), 0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_res_op", W'(res_op), 0);
        chk("mid_rst_res_valid", W'(res_valid), 0);
        chk("mid_rst_busy", W'(busy), 0);
        model_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("after_rst_ready", W'(cmd_ready), 1);
        chk("after_rst_busy", W'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            res_ready = 1'b1;
            chk("after_rst_no_result", W'(res_valid), 0);
            tick();
        end
        res_ready = 1'b0;

        // Randomized traffic against the in-order reference queue.
        sent = 0; got = 0;
        for (int c = 0; c < 3000 && got < NRAND; c++) begin
            if (!cmd_valid && sent < NRAND && $urandom_range(0, 2) != 0) begin
                cmd_valid = 1'b1;
                cmd_op    = 3'($urandom_range(0, 7));
                cmd_a     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                cmd_b     = $urandom;
            end
            res_ready = ($urandom_range(0, 3) != 0);
            if (res_valid && res_ready) begin
                take("rnd");
                got++;
            end
            acc = cmd_valid && cmd_ready;
            if (acc) begin
                model_q.push_back('{op: cmd_op, d: ref_alu(cmd_op, cmd_a, cmd_b)});
                sent++;
            end
            tick();
            if (acc) cmd_valid = 1'b0;
        end
        res_ready = 1'b0;
        chk("rnd_results", W'(got), W'(NRAND));
        r1 = W'(busy);
        chk("rnd_idle", r1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command front-end that sits directly upstream of the team's 32-bit combinational ALU (operands a/b, 3-bit opcode inp, result out).
- Accepts {opcode, a, b} commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives one command at a time onto registered ALU operand/opcode outputs.
- Captures the ALU result and presents it downstream on a valid/ready result port, tagged with its opcode.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- DEPTH, 4, command FIFO depth in entries; power of two, at least 2.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  upstream command present.
- cmd_ready  output  1  FIFO can accept a command this cycle.
- cmd_op  input  3  ALU opcode: 000 clr, 001 add, 010 sub, 011 shl1, 100 shr1, 101 and, 110 or, 111 xor.
- cmd_a  input  WIDTH  operand a.
- cmd_b  input  WIDTH  operand b.
- alu_a  output  WIDTH  registered operand a to ALU.
- alu_b  output  WIDTH  registered operand b to ALU.
- alu_inp  output  3  registered opcode to ALU.
- alu_out  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_inp).
- res_valid  output  1  result held on res_data.
- res_ready  input  1  downstream accepts result.
- res_data  output  WIDTH  captured ALU result.
- res_op  output  3  opcode that produced res_data.
- busy  output  1  high when FIFO is non-empty or state is not IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO pointers and count are 0, state IDLE, and all outputs are 0: alu_a, alu_b, alu_inp, res_data, res_op, res_valid, busy. cmd_ready becomes 1 on the first cycle after reset deasserts.
- Reset asserted mid-operation discards all queued commands and any pending result; nothing is replayed.
- Push: a command is written when cmd_valid && cmd_ready at a clock edge.
- cmd_ready = (count != DEPTH), derived from registered count only.
  - When full, no push occurs, even if a pop happens in the same cycle.
- Pop and push in the same cycle with count between 1 and DEPTH-1: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- State machine (IDLE, EXEC, HOLD):
  - IDLE: if FIFO is non-empty at an edge, pop the head into alu_a/alu_b/alu_inp and go to EXEC. Otherwise stay.
  - EXEC: at the next edge, res_data <= alu_out, res_op <= alu_inp, res_valid <= 1, go to HOLD.
  - HOLD: res_valid stays 1 and res_data/res_op stay stable until res_valid && res_ready at an edge. At that edge:
    - res_valid <= 0.
    - If the FIFO is non-empty, pop the next command directly and go to EXEC.
    - Otherwise go to IDLE.
- alu_a/alu_b/alu_inp hold their last issued values when not popping; they do not return to 0.
- Latency:
  - Command accepted at edge E0 → popped at E1 → res_valid high after E2 (2 cycles).
  - Back-to-back throughput is one result per 2 cycles while res_ready is held high.
- Ordering: results emerge in strict command order; no command is dropped or duplicated.
- Push into an empty FIFO while in IDLE is not bypassed: the pop occurs on the following edge.
- res_ready is ignored while res_valid is 0.
- Arithmetic is performed solely by the ALU; this block does no width adjustment or flag generation.

Test Plan:
- Reset then single add: cmd {001, 0x0000_0005, 0x0000_0003} → res_valid rises 2 edges after acceptance with res_data=0x0000_0008, res_op=001; busy returns to 0 one edge after handshake.
- Sub wrap-around: {010, 0x0000_0001, 0x0000_0002} → res_data=0xFFFF_FFFF. Clear op: {000, 0xDEAD_BEEF, 0x1234_5678} → res_data=0.
- Full FIFO with res_ready=0: push 5 commands (xor, or, and, shl1, shr1 with a=0xF0F0_F0F0, b=0x0FF0_0FF0).
  - cmd_ready drops after the FIFO holds 4 queued entries plus 1 in flight.
  - Result 1 = 0xFF00_FF00 is held stable for 10 cycles.
  - Releasing res_ready yields, in order: 0xFF00_FF00, 0xFFF0_FFF0, 0x00F0_00F0, 0xE1E1_E1E0, 0x7878_7878.
- Simultaneous push and pop: with count=2, push while HOLD completes → count stays 2 and order is preserved.
- Reset mid-operation: assert rst_n low while in EXEC with 3 queued → all outputs 0 immediately (asynchronous). After release, cmd_ready=1, busy=0, and no stale result appears.
